// File: rtl/design_switch_sequencer.sv
// Owns the design_sel bus feeding the pad mux and changes it glitch-free:
// reset held, pads quiesced, selection committed, settle window, then reset released.
module design_switch_sequencer #(
    parameter int unsigned QUIESCE_CYCLES = 16,
    parameter int unsigned SETTLE_CYCLES  = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic [4:0] boot_sel,
    input  logic [4:0] sel_req,
    input  logic       sel_req_valid,
    output logic       sel_req_ready,
    input  logic       lock_i,
    output logic [4:0] design_sel,
    output logic       io_quiesce,
    output logic       rst_release,
    output logic       busy,
    output logic       sel_done
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_QUIESCE = 2'd1,
        ST_SWITCH  = 2'd2,
        ST_SETTLE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] Q_LAST = CNT_W'(QUIESCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       design_sel_q, design_sel_d;
    logic [4:0]       pend_q, pend_d;
    logic             via_switch_q, via_switch_d;
    logic             io_quiesce_q, io_quiesce_d;
    logic             rst_release_q, rst_release_d;
    logic             busy_q, busy_d;
    logic             sel_done_q, sel_done_d;
    logic             accept;

    assign sel_req_ready = (state_q == ST_RUN) & ~lock_i;
    assign accept        = sel_req_valid & sel_req_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        design_sel_d = design_sel_q;
        pend_d       = pend_q;
        via_switch_d = via_switch_q;
        sel_done_d   = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (sel_req == design_sel_q) begin
                        sel_done_d = 1'b1;
                    end else begin
                        pend_d  = sel_req;
                        cnt_d   = '0;
                        state_d = ST_QUIESCE;
                    end
                end
            end
            ST_QUIESCE: begin
                if (cnt_q >= Q_LAST) state_d = ST_SWITCH;
                else                 cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_SWITCH: begin
                // Pads are already quiesced and designs held in reset here.
                design_sel_d = pend_q;
                cnt_d        = '0;
                via_switch_d = 1'b1;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q >= S_LAST) begin
                    state_d      = ST_RUN;
                    sel_done_d   = via_switch_q;
                    via_switch_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
        endcase

        io_quiesce_d  = (state_d != ST_RUN);
        rst_release_d = (state_d == ST_RUN);
        busy_d        = (state_d != ST_RUN);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q       <= ST_SETTLE;
            cnt_q         <= '0;
            design_sel_q  <= boot_sel;
            pend_q        <= boot_sel;
            via_switch_q  <= 1'b0;
            io_quiesce_q  <= 1'b1;
            rst_release_q <= 1'b0;
            busy_q        <= 1'b1;
            sel_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            design_sel_q  <= design_sel_d;
            pend_q        <= pend_d;
            via_switch_q  <= via_switch_d;
            io_quiesce_q  <= io_quiesce_d;
            rst_release_q <= rst_release_d;
            busy_q        <= busy_d;
            sel_done_q    <= sel_done_d;
        end
    end

    assign design_sel  = design_sel_q;
    assign io_quiesce  = io_quiesce_q;
    assign rst_release = rst_release_q;
    assign busy        = busy_q;
    assign sel_done    = sel_done_q;

endmodule

// File: tb/tb_design_switch_sequencer.sv
// Bench for design_switch_sequencer with 4-cycle quiesce and settle windows:
// vector table, reset-mid-switch sequence, then random traffic against a timeline model.
module tb_design_switch_sequencer;

    localparam int unsigned Q = 4;
    localparam int unsigned S = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] boot_sel;
    logic [4:0] sel_req;
    logic       sel_req_valid;
    logic       sel_req_ready;
    logic       lock_i;
    logic [4:0] design_sel;
    logic       io_quiesce;
    logic       rst_release;
    logic       busy;
    logic       sel_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    design_switch_sequencer #(
        .QUIESCE_CYCLES(Q),
        .SETTLE_CYCLES (S),
        .CNT_W         (8)
    ) dut (
        .clk_i        (clk),
        .rst_n        (rst_n),
        .boot_sel     (boot_sel),
        .sel_req      (sel_req),
        .sel_req_valid(sel_req_valid),
        .sel_req_ready(sel_req_ready),
        .lock_i       (lock_i),
        .design_sel   (design_sel),
        .io_quiesce   (io_quiesce),
        .rst_release  (rst_release),
        .busy         (busy),
        .sel_done     (sel_done)
    );

    // Timeline model: a switch accepted at edge n commits at n+Q+1 and returns to RUN at n+Q+S+1.
    int         edge_n     = 0;
    int         m_run_edge = 1 << 30;
    int         m_sel_edge = 0;
    logic [4:0] m_sel      = '0;
    logic [4:0] m_pend     = '0;
    logic       m_sw       = 1'b0;
    logic       m_done     = 1'b0;

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (!rst_n) begin
            m_sel      = boot_sel;
            m_run_edge = edge_n + S;
            m_sw       = 1'b0;
            m_done     = 1'b0;
        end else begin
            m_done = 1'b0;
            if (edge_n > m_run_edge && sel_req_valid && !lock_i) begin
                if (sel_req == m_sel) begin
                    m_done = 1'b1;
                end else begin
                    m_pend     = sel_req;
                    m_sel_edge = edge_n + Q + 1;
                    m_run_edge = edge_n + Q + S + 1;
                    m_sw       = 1'b1;
                end
            end
            if (m_sw && edge_n == m_sel_edge) m_sel = m_pend;
            if (m_sw && edge_n == m_run_edge) begin
                m_done = 1'b1;
                m_sw   = 1'b0;
            end
        end
    end

    typedef struct {
        logic       rst_n;
        logic [4:0] boot;
        logic [4:0] req;
        logic       valid;
        logic       lock;
        logic [4:0] e_sel;
        logic       e_run;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [4:0] b, input logic [4:0] rq,
                       input logic v, input logic l,
                       input logic [4:0] es, input logic er, input logic ed);
        vec_t x;
        x.rst_n = r; x.boot = b; x.req = rq; x.valid = v; x.lock = l;
        x.e_sel = es; x.e_run = er; x.e_done = ed;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [4:0] es, input logic run,
                              input logic done);
        chk({tag, ".design_sel"},  32'(design_sel),    32'(es));
        chk({tag, ".io_quiesce"},  32'(io_quiesce),    32'(!run));
        chk({tag, ".rst_release"}, 32'(rst_release),   32'(run));
        chk({tag, ".busy"},        32'(busy),          32'(!run));
        chk({tag, ".sel_done"},    32'(sel_done),      32'(done));
        chk({tag, ".ready"},       32'(sel_req_ready), 32'(run & !lock_i));
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; boot_sel = '0; sel_req = '0; sel_req_valid = 1'b0; lock_i = 1'b0;

        // Reset with strap 0x1E, then the 4-cycle settle window.
        for (int i = 0; i < 3; i++) add(0, 5'h1E, 5'h00, 0, 0, 5'h1E, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 5'h1E, 5'h00, 0, 0, 5'h1E, 0, 0);
        add(1, 5'h1E, 5'h00, 0, 0, 5'h1E, 1, 0);
        // Switch 0x1E -> 0x1B; sel_req changes after the accept are ignored.
        add(1, 5'h1E, 5'h1B, 1, 0, 5'h1E, 0, 0);
        for (int i = 1; i <= 4; i++) add(1, 5'h1E, 5'h07, 0, 0, 5'h1E, 0, 0);
        for (int i = 5; i <= 8; i++) add(1, 5'h1E, 5'h07, 0, 0, 5'h1B, 0, 0);
        add(1, 5'h1E, 5'h07, 0, 0, 5'h1B, 1, 1);
        add(1, 5'h1E, 5'h07, 0, 0, 5'h1B, 1, 0);
        // Same-selection request: immediate done, no quiesce.
        add(1, 5'h1E, 5'h1B, 1, 0, 5'h1B, 1, 1);
        add(1, 5'h1E, 5'h1B, 0, 0, 5'h1B, 1, 0);
        // Lock blocks a held request; dropping it accepts at once.
        add(1, 5'h1E, 5'h05, 1, 1, 5'h1B, 1, 0);
        add(1, 5'h1E, 5'h05, 1, 1, 5'h1B, 1, 0);
        add(1, 5'h1E, 5'h05, 1, 0, 5'h1B, 0, 0);
        // Competing requests and lock during the switch are ignored.
        add(1, 5'h1E, 5'h0A, 1, 0, 5'h1B, 0, 0);
        add(1, 5'h1E, 5'h0A, 1, 1, 5'h1B, 0, 0);
        add(1, 5'h1E, 5'h0A, 1, 0, 5'h1B, 0, 0);
        add(1, 5'h1E, 5'h0A, 1, 0, 5'h1B, 0, 0);
        for (int i = 5; i <= 8; i++) add(1, 5'h1E, 5'h0A, 1, 0, 5'h05, 0, 0);
        add(1, 5'h1E, 5'h0A, 1, 0, 5'h05, 1, 1);
        add(1, 5'h1E, 5'h0A, 0, 0, 5'h05, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n; boot_sel = vecs[i].boot; sel_req = vecs[i].req;
            sel_req_valid = vecs[i].valid; lock_i = vecs[i].lock;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_run, vecs[i].e_done);
        end

        // Reset three edges into a switch to 0x11: boot_sel wins, full settle restarts.
        boot_sel = 5'h03; sel_req = 5'h11; sel_req_valid = 1'b1;
        step();
        check_outs("abort_accept", 5'h05, 0, 0);
        sel_req_valid = 1'b0;
        step(); step();
        rst_n = 1'b0;
        step();
        check_outs("abort_rst0", 5'h03, 0, 0);
        step();
        check_outs("abort_rst1", 5'h03, 0, 0);
        rst_n = 1'b1;
        for (int k = 1; k <= int'(S); k++) begin
            step();
            check_outs($sformatf("abort_settle%0d", k), 5'h03, (k == int'(S)), 0);
        end
        repeat (Q + S + 2) begin
            step();
            check_outs("abort_hold", 5'h03, 1, 0);
        end

        // Random traffic against the timeline model.
        for (int c = 0; c < 3000; c++) begin
            rst_n         = ($urandom_range(0, 149) != 0);
            boot_sel      = 5'($urandom);
            sel_req       = ($urandom_range(0, 3) == 0) ? m_sel : 5'($urandom);
            sel_req_valid = ($urandom_range(0, 1) == 1);
            lock_i        = ($urandom_range(0, 4) == 0);
            step();
            check_outs($sformatf("rnd%0d", c), m_sel, (edge_n >= m_run_edge), m_done);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
